// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limit constants and validity helper for the multi-digit counter.
// Pure declarations; no latency or flow-control implications.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;

   function automatic logic is_valid_bcd(input bcd_digit_t v);
      return (v <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade stage: loads (invalid digit becomes 0) or steps up/down with 9<->0 rollover.
// Latency: q updates on the edge after step_in/load; at_limit is combinational from q and up.
// Backpressure: none, the stage steps whenever step_in is high.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       step_in,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       at_limit
`ifdef BCD_COUNTER_MATCH_EN
   ,
   output logic [3:0] q_nxt
`endif
);

   logic [3:0] q_q;
   logic [3:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = is_valid_bcd(d) ? d : BCD_MIN;
      end else if (step_in) begin
         if (up) begin
            q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
         end else begin
            q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         q_q <= BCD_MIN;
      end else begin
         q_q <= q_d;
      end
   end

   assign q        = q_q;
   assign at_limit = up ? (q_q == BCD_MAX) : (q_q == BCD_MIN);

`ifdef BCD_COUNTER_MATCH_EN
   assign q_nxt = q_d;
`endif

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with load checking; optional compare output under BCD_COUNTER_MATCH_EN.
// Latency: q/co/load_err/match one edge after the inputs; tc is combinational in the same cycle.
// Backpressure: none; enable gates all activity and tc chains into the next counter's enable.
module bcd_counter_multi
   import bcd_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter bit WRAP_EN = 1'b1
)
(
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  enable,
   input  logic                  load,
   input  logic                  up,
   input  logic [4*DIGITS-1:0]   d,
   output logic [4*DIGITS-1:0]   q,
   output logic                  co,
   output logic                  tc,
   output logic                  load_err
`ifdef BCD_COUNTER_MATCH_EN
   ,
   input  logic [4*DIGITS-1:0]   cmp,
   output logic                  match
`endif
);

   logic [DIGITS-1:0] lim;
   logic [DIGITS-1:0] step;
   logic [DIGITS-1:0] bad;
   logic              cnt;
   logic              all_lim;
   logic              co_q, co_d;
   logic              load_err_q, load_err_d;

   always_comb begin
      cnt     = enable & ~load;
      all_lim = &lim;
      // Saturating build suppresses the step at the limit but still reports it on co.
      step[0] = cnt & (WRAP_EN | ~all_lim);
      for (int i = 1; i < DIGITS; i++) begin
         step[i] = step[i-1] & lim[i-1];
      end
      for (int i = 0; i < DIGITS; i++) begin
         bad[i] = ~is_valid_bcd(d[4*i +: 4]);
      end
      co_d       = cnt & all_lim;
      load_err_d = enable & load & (|bad);
   end

   assign tc = cnt & all_lim;

`ifdef BCD_COUNTER_MATCH_EN
   logic [4*DIGITS-1:0] q_nxt;
`endif

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk      (clk),
         .clr      (clr),
         .step_in  (step[i]),
         .up       (up),
         .load     (enable & load),
         .d        (d[4*i +: 4]),
         .q        (q[4*i +: 4]),
         .at_limit (lim[i])
`ifdef BCD_COUNTER_MATCH_EN
         ,
         .q_nxt    (q_nxt[4*i +: 4])
`endif
      );
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         co_q       <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         co_q       <= co_d;
         load_err_q <= load_err_d;
      end
   end

   assign co       = co_q;
   assign load_err = load_err_q;

`ifdef BCD_COUNTER_MATCH_EN
   logic match_q, match_d;

   always_comb begin
      match_d = (q_nxt == cmp);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match_d;
      end
   end

   assign match = match_q;
`endif

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Bench for bcd_counter_multi: wrapping and saturating instances driven in lockstep against an integer model.
module tb_bcd_counter_multi;

   localparam int DIGITS = 3;
   localparam int W      = 4 * DIGITS;
   localparam int MAXV   = 999;

   logic         clk = 1'b0;
   logic         clr, enable, load, up;
   logic [W-1:0] d;
   logic [W-1:0] cmp;
   logic [W-1:0] q_o  [2];
   logic         co_o [2];
   logic         tc_o [2];
   logic         le_o [2];
   logic         mt_o [2];

   int mv  [2];
   bit mco [2];
   bit mle [2];
   bit mmt [2];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // index 0: saturating, index 1: wrapping
   bcd_counter_multi #(.DIGITS(DIGITS), .WRAP_EN(1'b0)) u_sat (
      .clk(clk), .clr(clr), .enable(enable), .load(load), .up(up), .d(d),
      .q(q_o[0]), .co(co_o[0]), .tc(tc_o[0]), .load_err(le_o[0])
`ifdef BCD_COUNTER_MATCH_EN
      , .cmp(cmp), .match(mt_o[0])
`endif
   );

   bcd_counter_multi #(.DIGITS(DIGITS), .WRAP_EN(1'b1)) u_wrap (
      .clk(clk), .clr(clr), .enable(enable), .load(load), .up(up), .d(d),
      .q(q_o[1]), .co(co_o[1]), .tc(tc_o[1]), .load_err(le_o[1])
`ifdef BCD_COUNTER_MATCH_EN
      , .cmp(cmp), .match(mt_o[1])
`endif
   );

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int from_load(input logic [W-1:0] x);
      int         v;
      logic [3:0] nib;
      v = 0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = x[4*i +: 4];
         v = v * 10 + ((nib > 4'd9) ? 0 : int'(nib));
      end
      return v;
   endfunction

   function automatic bit has_bad(input logic [W-1:0] x);
      bit b;
      b = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (x[4*i +: 4] > 4'd9) b = 1'b1;
      end
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         mco[k] = 1'b0;
         mle[k] = 1'b0;
         if (clr) begin
            mv[k]  = 0;
            mmt[k] = 1'b0;
         end else begin
            if (enable && load) begin
               mv[k]  = from_load(d);
               mle[k] = has_bad(d);
            end else if (enable) begin
               if (up) begin
                  if (mv[k] == MAXV) begin
                     mco[k] = 1'b1;
                     if (k == 1) mv[k] = 0;
                  end else begin
                     mv[k] = mv[k] + 1;
                  end
               end else begin
                  if (mv[k] == 0) begin
                     mco[k] = 1'b1;
                     if (k == 1) mv[k] = MAXV;
                  end else begin
                     mv[k] = mv[k] - 1;
                  end
               end
            end
            mmt[k] = (mv[k] == from_load(cmp));
         end
      end
   endtask

   task automatic tick(input bit do_tc);
      bit exp_tc;
      #1;
      if (do_tc) begin
         for (int k = 0; k < 2; k++) begin
            exp_tc = enable && !load && (up ? (mv[k] == MAXV) : (mv[k] == 0));
            chk($sformatf("tc[%0d]", k), 32'(tc_o[k]), 32'(exp_tc));
         end
      end
      @(posedge clk);
      model_edge();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("q[%0d]", k),        32'(q_o[k]),  32'(to_bcd(mv[k])));
         chk($sformatf("co[%0d]", k),       32'(co_o[k]), 32'(mco[k]));
         chk($sformatf("load_err[%0d]", k), 32'(le_o[k]), 32'(mle[k]));
`ifdef BCD_COUNTER_MATCH_EN
         chk($sformatf("match[%0d]", k),    32'(mt_o[k]), 32'(mmt[k]));
`endif
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         mv[k] = 0; mco[k] = 0; mle[k] = 0; mmt[k] = 0;
      end
      cmp    = 12'h005;
      clr    = 1'b1;
      enable = 1'($urandom);
      load   = 1'($urandom);
      up     = 1'($urandom);
      d      = 12'($urandom);
      tick(1'b0);
      tick(1'b1);

      clr = 1'b0; enable = 1'b1; load = 1'b0; up = 1'b1;
      repeat (12) tick(1'b1);

      load = 1'b1; d = 12'h998;
      tick(1'b1);
      load = 1'b0;
      repeat (2) tick(1'b1);

      load = 1'b1; d = 12'h001;
      tick(1'b1);
      load = 1'b0; up = 1'b0;
      repeat (2) tick(1'b1);
      up = 1'b1;
      tick(1'b1);

      load = 1'b1; d = 12'h9A3;
      tick(1'b1);
      enable = 1'b0; load = 1'b0;
      tick(1'b1);
      load = 1'b1; d = 12'h456;
      repeat (2) tick(1'b1);

      enable = 1'b1; load = 1'b1; d = 12'h999;
      tick(1'b1);
      load = 1'b0; up = 1'b1;
      repeat (3) tick(1'b1);
      clr = 1'b1;
      tick(1'b1);
      clr = 1'b0;
      tick(1'b1);

      cmp = 12'h005; clr = 1'b1;
      tick(1'b1);
      clr = 1'b0; up = 1'b1;
      repeat (8) tick(1'b1);

      for (int n = 0; n < 400; n++) begin
         clr    = ($urandom_range(0, 39) == 0);
         enable = ($urandom_range(0, 4) != 0);
         load   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) up = ~up;
         case ($urandom_range(0, 5))
            0: d = 12'h999;
            1: d = 12'h000;
            2: d = 12'h998;
            3: d = 12'h001;
            default: d = 12'($urandom);
         endcase
         if ($urandom_range(0, 19) == 0) cmp = to_bcd(int'($urandom_range(0, MAXV)));
         tick(1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
- Parametrised multi-digit BCD up/down counter; next generation of the single-digit BCD counter.
- DIGITS cascaded decade stages, parallel load with per-digit validity checking, registered wrap pulse, combinational terminal-count output for chaining.
- Used in display/timer datapaths where a decimal count wider than one digit is needed.

Parameters:
- DIGITS, 4, number of BCD digits (>=1); q width = 4*DIGITS, digit 0 = least significant at q[3:0].
- WRAP_EN, 1, 1 = wrap at limits (9..9 <-> 0..0); 0 = hold at limit (saturate), co still pulses on an attempted wrap.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous, active-high reset.
- enable  in  1  gates both load and count.
- load  in  1  parallel load of d when enable=1.
- up  in  1  1 = count up, 0 = count down.
- d  in  4*DIGITS  load value, packed BCD.
- q  out  4*DIGITS  current count, packed BCD.
- co  out  1  registered one-cycle wrap/limit pulse.
- tc  out  1  combinational terminal count for cascading.
- load_err  out  1  registered one-cycle pulse: a loaded digit was >9.

Behaviour:
- Reset: clr=1 at posedge -> q=0, co=0, load_err=0. clr has priority over every other input. Reset asserted mid-count is honoured on that edge, with no residual co.
- Priority at posedge: clr > (enable & load) > (enable & ~load count) > hold.
- Load: each digit i takes d[4i+3:4i] if <=9. A digit >9 is replaced by 0, and load_err=1 for the next cycle. co=0 on a load cycle.
- Count up: digit 0 increments. Digit i increments only when all lower digits =9; a digit at 9 that is stepped becomes 0.
- Count down: a digit at 0 that is stepped becomes 9. Digit i is stepped only when all lower digits =0.
- Wrap, up, from all-9 (or down from all-0):
  - WRAP_EN=1: q -> all-0 (or all-9), co=1 for exactly the following cycle, i.e. co is high while q shows the wrapped value.
  - WRAP_EN=0: q holds, co=1 for one cycle per attempted step.
- co and load_err are 0 on every cycle not described above, including enable=0 cycles.
- tc = enable & ~load & (up ? q==all-9 : q==all-0); it has no register and is valid within the same cycle. Chaining tc -> next counter's enable forms wider counters.
- Direction change takes effect on the next enabled edge; no extra latency.
- q is never outside valid BCD: digits stay 0..9 at all times after reset.

Optional Feature:
- Macro BCD_COUNTER_MATCH_EN.
- Defined: adds input cmp (4*DIGITS) and output match (1). match is registered and goes 1 for one cycle after any edge where the new q equals cmp. It is 0 after reset.
- Undefined: no cmp/match ports, no comparator logic; all other behaviour is identical.

Decomposition:
- Shared package bcd_pkg:
  - BCD_MAX = 4'd9, BCD_MIN = 4'd0 constants.
  - bcd_digit_t 4-bit typedef.
  - is_valid_bcd function.
- Sub-module bcd_digit: one decade stage with step_in, up, load, d, q and at_limit (9 when up, 0 when down). It is instantiated DIGITS times via generate; step chaining is done in the top.

Test Plan (DIGITS=3, WRAP_EN=1 unless noted):
- clr=1 with arbitrary inputs, then clr=0, enable=1, up=1 for 12 edges -> q steps 000..012, co never high.
- load d=998, then up for 2 edges -> q=999 then 000. co=1 only in the cycle q=000. tc=1 while q=999 and up=1.
- load d=001, up=0 for 2 edges -> 000 then 999 with co pulse. Then toggle up=1 -> 000 with co pulse.
- load d=0x9A3 -> q=903, load_err=1 for one cycle then 0. Assert enable=0 with load=1 -> q unchanged.
- WRAP_EN=0, load 999, up for 3 edges -> q stays 999, co=1 each cycle. clr asserted during the count -> q=000, co=0 next cycle.
- BCD_COUNTER_MATCH_EN defined, cmp=005, count up from 000 -> match=1 only in the cycle q=005.
